// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg
//   Shared definitions for the fetch/execute sequencer: FSM state encoding
//   and default configuration constants.
//   Optional build macro used by the sequencer: FETCH_TIMEOUT_EN.
package fetch_sequencer_pkg;

   typedef enum logic [1:0] {
      FETCH    = 2'd0,
      WAIT_ACK = 2'd1,
      EXECUTE  = 2'd2,
      HALT     = 2'd3
   } fs_state_e;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_3000;
   localparam int          DEFAULT_TIMEOUT      = 16;

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Instruction-memory request/acknowledge bus.
//   imem_req   - fetch request (sequencer -> memory)
//   imem_addr  - 30-bit word address of the fetch (sequencer -> memory)
//   imem_ack   - read data valid this cycle (memory -> sequencer)
//   imem_rdata - 32-bit instruction word (memory -> sequencer)
//   Modports: master = sequencer side, slave = memory side.
interface fetch_sequencer_if;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
   modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_sequencer_watchdog.sv
// fetch_watchdog
//   Clear/enable/terminal-count counter bounding how long a fetch may wait
//   for its acknowledge. Only instantiated when FETCH_TIMEOUT_EN is defined.
//   clk, rst - clock, synchronous active-high reset
//   clr      - hold count at zero (sequencer not waiting for an ack)
//   en       - a wait cycle passed without ack
//   expired  - this enabled cycle is the TIMEOUT-th one without ack
module fetch_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (en)
         count <= count + 1'b1;
   end

   // The count would reach TIMEOUT on this edge; flag it now so the FSM
   // leaves WAIT_ACK on the same edge. An ack drops en, so the ack wins.
   assign expired = en && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Multi-cycle fetch/execute sequencer. Owns the architectural word PC,
//   fetches over a variable-latency req/ack bus, holds the instruction while
//   execute runs, and commits npc_next when execute reports ex_done.
//   Optional build macro: FETCH_TIMEOUT_EN (fetch watchdog -> fetch_err + HALT).
//   Ports:
//     clk, rst     - clock, synchronous active-high reset
//     npc_next     - next word address, sampled at commit
//     pc           - current word PC
//     imem         - instruction memory bus (master side)
//     instr        - instruction register
//     instr_valid  - instr valid, execute may proceed
//     ex_done      - execute finished for current instr (commit)
//     halt_req     - halt after the committing instruction
//     halted       - sequencer is in HALT
//     fetch_err    - sticky fetch timeout flag
//     retired      - retired instruction count (wraps)
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int          TIMEOUT      = DEFAULT_TIMEOUT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [29:0]         npc_next,
   output logic [29:0]         pc,
   fetch_sequencer_if.master   imem,
   output logic [31:0]         instr,
   output logic                instr_valid,
   input  logic                ex_done,
   input  logic                halt_req,
   output logic                halted,
   output logic                fetch_err,
   output logic [31:0]         retired
);

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("fetch_sequencer: TIMEOUT must be at least 1");
   end

   fs_state_e state, state_nxt;
   logic      ack_take;
   logic      commit;
   logic      wd_expired;

   assign ack_take = (state == WAIT_ACK) && imem.imem_ack;
   assign commit   = (state == EXECUTE) && ex_done;

`ifdef FETCH_TIMEOUT_EN
   fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (state != WAIT_ACK),
      .en      ((state == WAIT_ACK) && !imem.imem_ack),
      .expired (wd_expired)
   );

   always_ff @(posedge clk) begin
      if (rst)
         fetch_err <= 1'b0;
      else if (wd_expired)
         fetch_err <= 1'b1;
   end
`else
   assign wd_expired = 1'b0;
   assign fetch_err  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_VECTOR[31:2];
         instr       <= '0;
         instr_valid <= 1'b0;
         retired     <= '0;
      end else begin
         state <= state_nxt;
         if (ack_take) begin
            instr       <= imem.imem_rdata;
            instr_valid <= 1'b1;
         end
         if (commit) begin
            pc          <= npc_next;
            retired     <= retired + 32'd1;
            instr_valid <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH:    state_nxt = WAIT_ACK;
         WAIT_ACK: begin
            if (imem.imem_ack)
               state_nxt = EXECUTE;
            else if (wd_expired)
               state_nxt = HALT;
         end
         EXECUTE:  begin
            if (ex_done)
               state_nxt = halt_req ? HALT : FETCH;
         end
         HALT:     state_nxt = HALT;
         default:  state_nxt = FETCH;
      endcase
   end

   // Request is state-decoded so FETCH drives it in its own cycle; masking
   // with rst keeps the bus quiet while reset is being applied.
   assign imem.imem_req  = !rst && ((state == FETCH) || (state == WAIT_ACK));
   assign imem.imem_addr = pc;
   assign halted         = !rst && (state == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Self-checking bench: table of fetch/execute records driven through a
//   memory model; expected instructions are queued when the ack is driven
//   and popped when the sequencer enters EXECUTE. Hand-written sequences
//   cover halt hold, reset mid-fetch and the fetch timeout (FETCH_TIMEOUT_EN).
module tb_fetch_sequencer;
   import fetch_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [29:0] npc_next;
   logic [29:0] pc;
   logic [31:0] instr;
   logic        instr_valid;
   logic        ex_done;
   logic        halt_req;
   logic        halted;
   logic        fetch_err;
   logic [31:0] retired;

   always #5 clk = ~clk;

   fetch_sequencer_if bus ();

   fetch_sequencer #(.RESET_VECTOR(32'h0000_3000), .TIMEOUT(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .npc_next    (npc_next),
      .pc          (pc),
      .imem        (bus),
      .instr       (instr),
      .instr_valid (instr_valid),
      .ex_done     (ex_done),
      .halt_req    (halt_req),
      .halted      (halted),
      .fetch_err   (fetch_err),
      .retired     (retired)
   );

   int checks = 0;
   int errors = 0;

   logic [29:0] m_pc;
   logic [31:0] m_ret;

   typedef struct {
      logic [31:0] instr;
      logic [29:0] pc;
   } sb_t;
   sb_t sbq[$];

   typedef struct {
      int          wait_n;
      logic [31:0] rdata;
      int          ex_delay;
      logic [29:0] npc;
      bit          halt;
   } vec_t;
   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Applies reset for one edge (with a stray ack that must be dropped),
   // checks the reset state, then releases reset in the FETCH state.
   task automatic do_reset();
      rst             = 1'b1;
      bus.imem_ack    = 1'b1;
      bus.imem_rdata  = 32'hBAD0_BAD0;
      ex_done         = 1'b0;
      halt_req        = 1'b0;
      @(negedge clk);
      chk("rst_pc",        32'(pc),          32'h0000_0C00);
      chk("rst_instr",     instr,            32'h0);
      chk("rst_ivalid",    32'(instr_valid), 32'd0);
      chk("rst_req",       32'(bus.imem_req), 32'd0);
      chk("rst_halted",    32'(halted),      32'd0);
      chk("rst_fetch_err", 32'(fetch_err),   32'd0);
      chk("rst_retired",   retired,          32'd0);
      rst          = 1'b0;
      bus.imem_ack = 1'b0;
      m_pc         = 30'h0C00;
      m_ret        = 32'd0;
      sbq.delete();
      #1;
   endtask

   // Entered at a negedge in FETCH. Holds ack low for wait_n WAIT_ACK
   // cycles, acks in the next one, and checks the EXECUTE entry.
   task automatic do_fetch(input int wait_n, input logic [31:0] rdata);
      sb_t e;
      chk("fetch_req",    32'(bus.imem_req),  32'd1);
      chk("fetch_addr",   32'(bus.imem_addr), 32'(m_pc));
      chk("fetch_ivalid", 32'(instr_valid),   32'd0);
      bus.imem_ack   = 1'b1;   // ack is never sampled in FETCH
      bus.imem_rdata = 32'hFEED_0000;
      @(negedge clk);
      bus.imem_ack = 1'b0;
      for (int i = 0; i < wait_n; i++) begin
         bus.imem_rdata = $urandom;
         #1;
         chk("wait_req",    32'(bus.imem_req),  32'd1);
         chk("wait_addr",   32'(bus.imem_addr), 32'(m_pc));
         chk("wait_ivalid", 32'(instr_valid),   32'd0);
         @(negedge clk);
      end
      chk("ack_req",  32'(bus.imem_req),  32'd1);
      chk("ack_addr", 32'(bus.imem_addr), 32'(m_pc));
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = rdata;
      e.instr = rdata;
      e.pc    = m_pc;
      sbq.push_back(e);
      @(negedge clk);
      bus.imem_ack = 1'b0;
      if (sbq.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sbq.pop_front();
         chk("ex_instr",  instr,             e.instr);
         chk("ex_pc",     32'(pc),           32'(e.pc));
         chk("ex_ivalid", 32'(instr_valid),  32'd1);
         chk("ex_req",    32'(bus.imem_req), 32'd0);
      end
   endtask

   // Entered at a negedge in EXECUTE. Stalls ex_delay cycles with stray
   // acks and an early halt_req (both must be ignored), then commits.
   task automatic do_exec(input int ex_delay, input logic [29:0] npc, input bit halt);
      logic [31:0] held;
      held = instr;
      for (int i = 0; i < ex_delay; i++) begin
         ex_done        = 1'b0;
         halt_req       = (i == 0);
         bus.imem_ack   = 1'b1;
         bus.imem_rdata = ~held;
         npc_next       = 30'($urandom);
         @(negedge clk);
         chk("stall_instr",  instr,             held);
         chk("stall_ivalid", 32'(instr_valid),  32'd1);
         chk("stall_pc",     32'(pc),           32'(m_pc));
         chk("stall_req",    32'(bus.imem_req), 32'd0);
         chk("stall_halted", 32'(halted),       32'd0);
      end
      bus.imem_ack = 1'b0;
      ex_done      = 1'b1;
      halt_req     = halt;
      npc_next     = npc;
      @(negedge clk);
      ex_done  = 1'b0;
      halt_req = 1'b0;
      npc_next = 30'($urandom);
      m_pc     = npc;
      m_ret    = m_ret + 32'd1;
      chk("commit_pc",      32'(pc),          32'(m_pc));
      chk("commit_retired", retired,          m_ret);
      chk("commit_ivalid",  32'(instr_valid), 32'd0);
      chk("commit_halted",  32'(halted),      32'(halt));
      if (halt) begin
         chk("commit_req_off", 32'(bus.imem_req), 32'd0);
      end else begin
         chk("commit_req_on", 32'(bus.imem_req),  32'd1);
         chk("commit_addr",   32'(bus.imem_addr), 32'(m_pc));
      end
   endtask

   initial begin
      rst            = 1'b1;
      npc_next       = '0;
      ex_done        = 1'b0;
      halt_req       = 1'b0;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = '0;
      m_pc           = 30'h0C00;
      m_ret          = '0;

      //             wait  rdata          exdly npc            halt
      vecs[0]  = '{0, 32'h2008_0005, 0, 30'h0000_0C01, 1'b0};
      vecs[1]  = '{5, 32'h8C22_0004, 2, 30'h0000_0C02, 1'b0};
      vecs[2]  = '{2, 32'hAC23_0008, 3, 30'h0000_0C04, 1'b0};
      vecs[3]  = '{1, 32'h0000_000C, 1, 30'h0000_0C05, 1'b1};
      vecs[4]  = '{0, 32'h1111_0001, 0, 30'h0000_0C10, 1'b0};
      vecs[5]  = '{3, 32'h2222_0002, 1, 30'h3FFF_FFFF, 1'b0};
      vecs[6]  = '{1, 32'h3333_0003, 0, 30'h0000_0000, 1'b0};
      vecs[7]  = '{0, 32'h4444_0004, 2, 30'h2AAA_AAAA, 1'b0};
      vecs[8]  = '{4, 32'h5555_0005, 0, 30'h1555_5555, 1'b0};
      vecs[9]  = '{1, 32'h6666_0006, 1, 30'h0000_0C00, 1'b0};
      vecs[10] = '{2, 32'h7777_0007, 0, 30'h0000_0C08, 1'b0};

      @(negedge clk);
      do_reset();

      // First program: ends with commit + halt at 0x0C05.
      for (int i = 0; i < 4; i++) begin
         do_fetch(vecs[i].wait_n, vecs[i].rdata);
         do_exec(vecs[i].ex_delay, vecs[i].npc, vecs[i].halt);
      end

      for (int i = 0; i < 20; i++) begin
         bus.imem_ack = 1'b1;
         npc_next     = 30'($urandom);
         @(negedge clk);
         chk("halt_req",    32'(bus.imem_req), 32'd0);
         chk("halt_halted", 32'(halted),       32'd1);
         chk("halt_pc",     32'(pc),           32'h0000_0C05);
         chk("halt_ivalid", 32'(instr_valid),  32'd0);
      end
      bus.imem_ack = 1'b0;

      // Second program: seven retirements including 30-bit PC wrap.
      do_reset();
      for (int i = 4; i < 11; i++) begin
         do_fetch(vecs[i].wait_n, vecs[i].rdata);
         do_exec(vecs[i].ex_delay, vecs[i].npc, vecs[i].halt);
      end
      chk("pre_rst_retired", retired, 32'd7);

      // Reset in the middle of WAIT_ACK.
      @(negedge clk);
      @(negedge clk);
      chk("midwait_req", 32'(bus.imem_req), 32'd1);
      do_reset();
      do_fetch(0, 32'hCAFE_0001);

`ifdef FETCH_TIMEOUT_EN
      do_exec(0, 30'h0000_0C20, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 15; i++) begin
         chk("to_wait_req", 32'(bus.imem_req), 32'd1);
         chk("to_wait_err", 32'(fetch_err),    32'd0);
         @(negedge clk);
      end
      chk("to_last_req", 32'(bus.imem_req), 32'd1);
      @(negedge clk);
      chk("to_fetch_err", 32'(fetch_err),    32'd1);
      chk("to_halted",    32'(halted),       32'd1);
      chk("to_req",       32'(bus.imem_req), 32'd0);
      chk("to_pc",        32'(pc),           32'h0000_0C20);
      repeat (3) @(negedge clk);
      chk("to_err_sticky", 32'(fetch_err), 32'd1);

      do_reset();
      do_fetch(15, 32'hDEAD_BEEF);
      chk("ack16_fetch_err", 32'(fetch_err), 32'd0);
      chk("ack16_halted",    32'(halted),    32'd0);
`else
      do_exec(0, 30'h0000_0C20, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         chk("nto_req",    32'(bus.imem_req),  32'd1);
         chk("nto_addr",   32'(bus.imem_addr), 32'h0000_0C20);
         chk("nto_err",    32'(fetch_err),     32'd0);
         chk("nto_halted", 32'(halted),        32'd0);
         @(negedge clk);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle fetch/execute sequencer that owns the architectural PC and drives the next-address datapath.
- Presents the 30-bit word PC to the next-PC logic and requests instructions from a variable-latency instruction memory over a req/ack handshake.
- Holds the fetched instruction stable while the execute datapath runs.
- Commits the next-PC result only when execute signals completion.

Parameters:
- RESET_VECTOR, 32'h0000_3000, byte reset address; bits [1:0] ignored, PC resets to RESET_VECTOR[31:2].
- TIMEOUT, 16, max cycles in WAIT_ACK before fetch error (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- npc_next  in  30  next word address from next-PC logic, sampled on commit.
- pc  out  30  current word PC, feeds next-PC logic PC input.
- imem_req  out  1  fetch request.
- imem_addr  out  30  word address of fetch; equals pc.
- imem_ack  in  1  memory has valid data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- instr  out  32  instruction register.
- instr_valid  out  1  instr is valid and execute may proceed.
- ex_done  in  1  execute/writeback finished for current instr.
- halt_req  in  1  stop after current instruction (syscall/break).
- halted  out  1  sequencer in HALT.
- fetch_err  out  1  sticky fetch-timeout flag.
- retired  out  32  retired instruction count.

Behaviour:
- States: FETCH, WAIT_ACK, EXECUTE, HALT.
- Reset (any state, any cycle):
  - state=FETCH, pc=RESET_VECTOR[31:2], instr=0.
  - instr_valid=0, imem_req=0, halted=0, fetch_err=0, retired=0.
  - An ack arriving in the reset cycle is discarded.
- FETCH:
  - Asserts imem_req=1, imem_addr=pc.
  - Next cycle goes to WAIT_ACK. Ack is never sampled in FETCH.
- WAIT_ACK:
  - imem_req held 1 and imem_addr held stable until ack.
  - On imem_ack=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0, go EXECUTE.
  - Minimum fetch latency: 2 cycles from entering FETCH to instr_valid.
- EXECUTE:
  - instr and pc held constant.
  - imem_ack while in EXECUTE is ignored.
  - On ex_done=1 (commit), all in the same edge:
    - pc<=npc_next, retired<=retired+1 (wraps 2^32-1 -> 0), instr_valid<=0.
    - If halt_req=1 in the same cycle, go HALT; else go FETCH.
  - halt_req without ex_done has no effect.
- HALT:
  - imem_req=0, instr_valid=0, halted=1.
  - pc keeps the committed next address. Only rst exits.
- npc_next is sampled only at commit; its value in other states is don't-care.
- pc wraps naturally at 30 bits; no range checking.
- Back-to-back: commit -> FETCH in the next cycle, so steady-state CPI = 3 + memory wait cycles.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle without ack.
  - When count reaches TIMEOUT with no ack: fetch_err<=1 (sticky until rst), imem_req<=0, go HALT, pc unchanged.
  - An ack in the same cycle the count reaches TIMEOUT wins: normal fetch, no error.
- FETCH_TIMEOUT_EN undefined:
  - No counter; WAIT_ACK waits indefinitely.
  - fetch_err is tied 0.

Decomposition:
- Shared package/header: state encodings (FETCH=2'd0, WAIT_ACK=2'd1, EXECUTE=2'd2, HALT=2'd3) and default RESET_VECTOR constant.
- One natural sub-module, fetch_watchdog: a clear/enable/terminal-count counter parameterised by TIMEOUT, instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Reset then ack after 1 wait cycle with rdata=32'h2008_0005 -> pc=0x0C00, imem_addr=0x0C00, instr=32'h2008_0005, instr_valid=1 in cycle 3.
- Commit with npc_next=0x0C01, then the next fetch acks -> pc=0x0C01, retired=1, imem_addr=0x0C01 on next imem_req.
- Hold ack low 5 cycles -> imem_req and imem_addr stable all 5 cycles. Ack during EXECUTE -> instr unchanged.
- ex_done=1 and halt_req=1 with npc_next=0x0C05 -> halted=1, pc=0x0C05, imem_req stays 0 for 20 cycles.
- FETCH_TIMEOUT_EN, TIMEOUT=16, no ack -> fetch_err=1 and halted=1 after 16 WAIT_ACK cycles. Repeat with ack on cycle 16 -> no error.
- rst asserted mid-WAIT_ACK with retired=7 -> next cycle state=FETCH, pc=0x0C00, retired=0, fetch_err=0.
